// File: rtl/nibble_register_loader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : nibble_register_loader
// Purpose  : Write-side driver for a bank of active-low-latched registers that
//            share one data bus. A packed word and a per-register write mask
//            are accepted over valid/ready; each enabled nibble is presented on
//            B (optionally with setup cycles) and its latch strobe is pulsed
//            low for exactly one cycle, in ascending register order.
// Ports    : clk       - rising-edge clock
//            rst_b     - asynchronous active-low reset
//            in_valid  - request holds a word to load
//            in_ready  - loader idle, can accept a request
//            in_word   - packed data, nibble i at [i*DATA_W +: DATA_W]
//            in_mask   - bit i set = load register i
//            B         - shared register data bus (registered)
//            latch_b   - active-low per-register load strobes (registered)
//            busy      - high in every state except IDLE
//            done      - single-cycle pulse after the last strobe
// Revision : 1.0 - initial release
// ============================================================================
module nibble_register_loader #(
    parameter int NUM_REGS     = 4,
    parameter int DATA_W       = 4,
    parameter int SETUP_CYCLES = 1
) (
    input  logic                         clk,
    input  logic                         rst_b,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [NUM_REGS*DATA_W-1:0]   in_word,
    input  logic [NUM_REGS-1:0]          in_mask,
    output logic [DATA_W-1:0]            B,
    output logic [NUM_REGS-1:0]          latch_b,
    output logic                         busy,
    output logic                         done
);

    localparam int         IDX_W    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    // Counter preload: SETUP lasts CNT_LOAD+1 cycles.
    localparam logic [1:0] CNT_LOAD = (SETUP_CYCLES > 0) ? 2'(SETUP_CYCLES - 1) : 2'd0;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_STROBE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t                       state_q;
    logic [NUM_REGS*DATA_W-1:0]   word_q;
    logic [NUM_REGS-1:0]          mask_q;     // bits still to be served
    logic [IDX_W-1:0]             idx_q;
    logic [1:0]                   cnt_q;
    logic [DATA_W-1:0]            bus_q;
    logic [NUM_REGS-1:0]          latch_q;
    logic                         busy_q;
    logic                         done_q;
    logic                         ready_q;

    logic [NUM_REGS-1:0]          rem_mask_d;
    logic [IDX_W-1:0]             next_idx_d;
    logic [IDX_W-1:0]             first_idx_d;

    // Lowest set bit wins: scanning downward lets the lowest index overwrite.
    function automatic logic [IDX_W-1:0] lowest_set(input logic [NUM_REGS-1:0] m);
        lowest_set = '0;
        for (int i = NUM_REGS - 1; i >= 0; i--) begin
            if (m[i]) lowest_set = IDX_W'(i);
        end
    endfunction

    function automatic logic [NUM_REGS-1:0] onehot(input logic [IDX_W-1:0] i);
        onehot    = '0;
        onehot[i] = 1'b1;
    endfunction

    function automatic logic [DATA_W-1:0] nibble(input logic [NUM_REGS*DATA_W-1:0] w,
                                                 input logic [IDX_W-1:0]           i);
        nibble = w[i*DATA_W +: DATA_W];
    endfunction

    always_comb begin
        rem_mask_d  = mask_q & ~onehot(idx_q);
        next_idx_d  = lowest_set(rem_mask_d);
        first_idx_d = lowest_set(in_mask);
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q <= S_IDLE;
            word_q  <= '0;
            mask_q  <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            bus_q   <= '0;
            latch_q <= '1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (in_valid && ready_q) begin
                        word_q  <= in_word;
                        mask_q  <= in_mask;
                        busy_q  <= 1'b1;
                        ready_q <= 1'b0;
                        if (in_mask == '0) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            idx_q <= first_idx_d;
                            // Bus is driven straight from the input because
                            // word_q only holds the word after this edge.
                            bus_q <= nibble(in_word, first_idx_d);
                            if (SETUP_CYCLES == 0) begin
                                state_q <= S_STROBE;
                                latch_q <= ~onehot(first_idx_d);
                            end else begin
                                state_q <= S_SETUP;
                                cnt_q   <= CNT_LOAD;
                            end
                        end
                    end
                end
                S_SETUP: begin
                    if (cnt_q == 2'd0) begin
                        state_q <= S_STROBE;
                        latch_q <= ~onehot(idx_q);
                    end else begin
                        cnt_q <= cnt_q - 2'd1;
                    end
                end
                S_STROBE: begin
                    // Strobe release and bus update share this edge, so the
                    // register captures the held nibble before B can move.
                    latch_q <= '1;
                    mask_q  <= rem_mask_d;
                    if (rem_mask_d == '0) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                    end else begin
                        idx_q <= next_idx_d;
                        bus_q <= nibble(word_q, next_idx_d);
                        if (SETUP_CYCLES == 0) begin
                            latch_q <= ~onehot(next_idx_d);
                        end else begin
                            state_q <= S_SETUP;
                            cnt_q   <= CNT_LOAD;
                        end
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    ready_q <= 1'b1;
                end
                default: begin
                    state_q <= S_IDLE;
                    latch_q <= '1;
                    busy_q  <= 1'b0;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready = ready_q;
    assign B        = bus_q;
    assign latch_b  = latch_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule
`default_nettype wire

// File: tb/tb_nibble_register_loader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_nibble_register_loader
// Purpose  : Directed self-checking bench. Two loaders are instantiated, one
//            with SETUP_CYCLES=1 and one with SETUP_CYCLES=0; each drives a
//            small model register bank that captures B on a rising edge while
//            its latch_b bit is low.
// Revision : 1.0 - initial release
// ============================================================================
module tb_nibble_register_loader;

    logic        clk;
    logic        rst_b;

    logic        iv1, rdy1, busy1, done1;
    logic [15:0] w1;
    logic [3:0]  m1, B1, lb1;

    logic        iv0, rdy0, busy0, done0;
    logic [15:0] w0;
    logic [3:0]  m0, B0, lb0;

    logic [15:0] regs1 = 16'h0000;
    logic [15:0] regs0 = 16'h0000;

    int errors = 0;
    int checks = 0;

    nibble_register_loader #(.NUM_REGS(4), .DATA_W(4), .SETUP_CYCLES(1)) u_dut1 (
        .clk(clk), .rst_b(rst_b), .in_valid(iv1), .in_ready(rdy1),
        .in_word(w1), .in_mask(m1), .B(B1), .latch_b(lb1),
        .busy(busy1), .done(done1)
    );

    nibble_register_loader #(.NUM_REGS(4), .DATA_W(4), .SETUP_CYCLES(0)) u_dut0 (
        .clk(clk), .rst_b(rst_b), .in_valid(iv0), .in_ready(rdy0),
        .in_word(w0), .in_mask(m0), .B(B0), .latch_b(lb0),
        .busy(busy0), .done(done0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External register bank models.
    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (!lb1[i]) regs1[i*4 +: 4] <= B1;
            if (!lb0[i]) regs0[i*4 +: 4] <= B0;
        end
    end

    // Vector layout: {B, latch_b, busy, done, in_ready}
    task automatic test_reset();
        rst_b = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_b = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({B1, lb1, busy1, done1, rdy1} !== {4'h0, 4'b1111, 3'b001}) begin
            errors++;
            $display("FAIL reset_dut1: got %h want %h", {B1, lb1, busy1, done1, rdy1}, {4'h0, 4'b1111, 3'b001});
        end
        checks++;
        if ({B0, lb0, busy0, done0, rdy0} !== {4'h0, 4'b1111, 3'b001}) begin
            errors++;
            $display("FAIL reset_dut0: got %h want %h", {B0, lb0, busy0, done0, rdy0}, {4'h0, 4'b1111, 3'b001});
        end
    endtask

    task automatic test_full_load();
        logic [10:0] exp_v [10];
        exp_v = '{{4'h3, 4'b1111, 3'b100}, {4'h3, 4'b1110, 3'b100},
                  {4'hC, 4'b1111, 3'b100}, {4'hC, 4'b1101, 3'b100},
                  {4'h5, 4'b1111, 3'b100}, {4'h5, 4'b1011, 3'b100},
                  {4'hA, 4'b1111, 3'b100}, {4'hA, 4'b0111, 3'b100},
                  {4'hA, 4'b1111, 3'b110}, {4'hA, 4'b1111, 3'b001}};
        iv1 = 1'b1; w1 = 16'hA5C3; m1 = 4'b1111;
        @(posedge clk); #1;
        iv1 = 1'b0; w1 = 16'h0000; m1 = 4'b0000;
        for (int c = 0; c < 10; c++) begin
            checks++;
            if ({B1, lb1, busy1, done1, rdy1} !== exp_v[c]) begin
                errors++;
                $display("FAIL full_load cycle %0d: got %h want %h", c + 1, {B1, lb1, busy1, done1, rdy1}, exp_v[c]);
            end
            @(posedge clk); #1;
        end
        checks++;
        if (regs1 !== 16'hA5C3) begin
            errors++;
            $display("FAIL full_load_regs: got %h want %h", regs1, 16'hA5C3);
        end
    endtask

    task automatic test_sparse_mask();
        logic [10:0] exp_v [6];
        exp_v = '{{4'h3, 4'b1111, 3'b100}, {4'h3, 4'b1101, 3'b100},
                  {4'h1, 4'b1111, 3'b100}, {4'h1, 4'b0111, 3'b100},
                  {4'h1, 4'b1111, 3'b110}, {4'h1, 4'b1111, 3'b001}};
        iv1 = 1'b1; w1 = 16'h1234; m1 = 4'b1010;
        @(posedge clk); #1;
        iv1 = 1'b0;
        for (int c = 0; c < 6; c++) begin
            checks++;
            if ({B1, lb1, busy1, done1, rdy1} !== exp_v[c]) begin
                errors++;
                $display("FAIL sparse cycle %0d: got %h want %h", c + 1, {B1, lb1, busy1, done1, rdy1}, exp_v[c]);
            end
            @(posedge clk); #1;
        end
        checks++;
        if (regs1 !== 16'h1533) begin
            errors++;
            $display("FAIL sparse_regs: got %h want %h", regs1, 16'h1533);
        end
    endtask

    task automatic test_zero_mask();
        logic [10:0] exp_v [2];
        exp_v = '{{4'h1, 4'b1111, 3'b110}, {4'h1, 4'b1111, 3'b001}};
        iv1 = 1'b1; w1 = 16'hFFFF; m1 = 4'b0000;
        @(posedge clk); #1;
        iv1 = 1'b0;
        for (int c = 0; c < 2; c++) begin
            checks++;
            if ({B1, lb1, busy1, done1, rdy1} !== exp_v[c]) begin
                errors++;
                $display("FAIL zero_mask cycle %0d: got %h want %h", c + 1, {B1, lb1, busy1, done1, rdy1}, exp_v[c]);
            end
            @(posedge clk); #1;
        end
        checks++;
        if (regs1 !== 16'h1533) begin
            errors++;
            $display("FAIL zero_mask_regs: got %h want %h", regs1, 16'h1533);
        end
    endtask

    task automatic test_back_to_back();
        logic [10:0] exp_v [8];
        exp_v = '{{4'h7, 4'b1110, 3'b100}, {4'h8, 4'b1101, 3'b100},
                  {4'h8, 4'b1111, 3'b110}, {4'h8, 4'b1111, 3'b001},
                  {4'hE, 4'b1110, 3'b100}, {4'h5, 4'b1101, 3'b100},
                  {4'h5, 4'b1111, 3'b110}, {4'h5, 4'b1111, 3'b001}};
        iv0 = 1'b1; w0 = 16'h0087; m0 = 4'b0011;
        @(posedge clk); #1;
        for (int c = 0; c < 8; c++) begin
            if (c == 0) w0 = 16'h005E;   // change while busy: must not affect request 1
            if (c == 6) iv0 = 1'b0;      // only two requests
            checks++;
            if ({B0, lb0, busy0, done0, rdy0} !== exp_v[c]) begin
                errors++;
                $display("FAIL b2b cycle %0d: got %h want %h", c + 1, {B0, lb0, busy0, done0, rdy0}, exp_v[c]);
            end
            if (c == 3) begin
                checks++;
                if (regs0[7:0] !== 8'h87) begin
                    errors++;
                    $display("FAIL b2b_regs_first: got %h want %h", regs0[7:0], 8'h87);
                end
            end
            @(posedge clk); #1;
        end
        checks++;
        if (regs0[7:0] !== 8'h5E) begin
            errors++;
            $display("FAIL b2b_regs_second: got %h want %h", regs0[7:0], 8'h5E);
        end
    endtask

    task automatic test_reset_abort();
        logic [10:0] exp_v [4];
        exp_v = '{{4'hF, 4'b1111, 3'b100}, {4'hF, 4'b1110, 3'b100},
                  {4'hF, 4'b1111, 3'b110}, {4'hF, 4'b1111, 3'b001}};
        iv1 = 1'b1; w1 = 16'h9876; m1 = 4'b1111;
        @(posedge clk); #1;
        iv1 = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (lb1 !== 4'b1110) begin
            errors++;
            $display("FAIL abort_strobe_seen: got %b want %b", lb1, 4'b1110);
        end
        #2 rst_b = 1'b0;
        #1;
        checks++;
        if ({B1, lb1, busy1, done1, rdy1} !== {4'h0, 4'b1111, 3'b001}) begin
            errors++;
            $display("FAIL abort_async: got %h want %h", {B1, lb1, busy1, done1, rdy1}, {4'h0, 4'b1111, 3'b001});
        end
        for (int c = 0; c < 2; c++) begin
            @(posedge clk); #1;
            checks++;
            if (done1 !== 1'b0 || lb1 !== 4'b1111) begin
                errors++;
                $display("FAIL abort_hold %0d: got done=%b latch=%b want done=0 latch=1111", c, done1, lb1);
            end
        end
        rst_b = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({B1, lb1, busy1, done1, rdy1} !== {4'h0, 4'b1111, 3'b001}) begin
            errors++;
            $display("FAIL abort_release: got %h want %h", {B1, lb1, busy1, done1, rdy1}, {4'h0, 4'b1111, 3'b001});
        end
        checks++;
        if (regs1[3:0] !== 4'h3) begin
            errors++;
            $display("FAIL abort_no_capture: got %h want %h", regs1[3:0], 4'h3);
        end
        iv1 = 1'b1; w1 = 16'hBEEF; m1 = 4'b0001;
        @(posedge clk); #1;
        iv1 = 1'b0;
        for (int c = 0; c < 4; c++) begin
            checks++;
            if ({B1, lb1, busy1, done1, rdy1} !== exp_v[c]) begin
                errors++;
                $display("FAIL abort_fresh cycle %0d: got %h want %h", c + 1, {B1, lb1, busy1, done1, rdy1}, exp_v[c]);
            end
            @(posedge clk); #1;
        end
        checks++;
        if (regs1[3:0] !== 4'hF) begin
            errors++;
            $display("FAIL abort_fresh_regs: got %h want %h", regs1[3:0], 4'hF);
        end
    endtask

    initial begin
        rst_b = 1'b0;
        iv1 = 1'b0; w1 = 16'h0000; m1 = 4'b0000;
        iv0 = 1'b0; w0 = 16'h0000; m0 = 4'b0000;
        test_reset();
        test_full_load();
        test_sparse_mask();
        test_zero_mask();
        test_back_to_back();
        test_reset_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
